bin2sseg_fmt: RTL
=================

# bin2sseg_fmt

Upstream formatter for the 8-digit time-multiplexed seven-segment driver. It accepts a 27-bit unsigned binary value with a valid/ready handshake and converts it iteratively (shift-add-3) to eight BCD digits. It then encodes the digits as active-low segment bytes, with optional leading-zero blanking and per-digit decimal points. It holds the eight registered bytes on `data_o` for the display mux's `data_i`.

## Interface
- No parameters; widths are fixed (27-bit input, 8 digits, 8-bit segment bytes).
- `clk_i` input 1: system clock (100 MHz).
- `rstn_i` input 1: reset, asynchronous, active-low.
- `valid_i` input 1: request; `bin_i`, `dp_i` and `blank_lz_i` are valid.
- `ready_o` output 1: block idle; a request is accepted on a rising edge where `valid_i & ready_o`.
- `bin_i` input 27: unsigned value to display; the legal range is 0..99_999_999.
- `dp_i` input 8: bit k = 1 lights the decimal point of digit k.
- `blank_lz_i` input 1: 1 blanks leading zeros.
- `data_o` output 8 x [0:7]: segment byte per digit. Index 0 is the least-significant, rightmost digit.
- `done_o` output 1: one-cycle pulse; `data_o` has just been updated.
- `ovf_o` output 1: the last accepted value was above 99_999_999. Held until the next update.

## Operation
- Segment byte format:
  - bit0..bit6 = segments a..g, bit7 = dp; 0 = lit.
  - Digit codes 0..9: C0 F9 A4 B0 99 92 82 F8 80 90 (hex).
  - Blank = FF; dash = BF.
  - A lit dp clears bit7; this applies to blanked digits too (blank with dp = 7F).
- FSM states:
  - IDLE: `ready_o`=1.
    - On accept, capture `bin_i` into the shift register, clear the 32-bit BCD register and the iteration counter, and latch `dp_i` and `blank_lz_i`.
    - Set an internal ovf flag = (`bin_i` > 99_999_999).
    - Go to CONV.
  - CONV: 27 iterations, one per clock.
    - Each iteration: every BCD nibble >= 5 gets +3, then {bcd, bin} shifts left by 1.
    - After the 27th iteration go to ENC.
    - The iteration counter is 5 bits and counts 0..26.
  - ENC: one cycle.
    - Register all eight `data_o` bytes and set `ovf_o` = ovf flag.
    - Pulse `done_o`; return to IDLE.
- The CONV length is constant, including for overflow values; the BCD result is then discarded.
- Leading-zero blanking, when the latched `blank_lz_i` = 1:
  - Digit k (7..1) is blanked when it and every higher digit are 0.
  - Digit 0 is never blanked; value 0 shows "0".
- Overflow: all eight digits show a dash (BF), dp still applied, and no blanking.
- `valid_i` while `ready_o`=0 is ignored; nothing is queued, and the upstream must hold or re-present the request.
- `data_o` holds its last value between conversions and during CONV; there is no intermediate update.

## Timing
- Reset (asynchronous, any state, including mid-CONV):
  - State = IDLE; `ready_o`=1, `done_o`=0, `ovf_o`=0, every `data_o` byte = FF (display dark).
  - The counter and shift registers are cleared.
  - No `done_o` for the aborted conversion.
- Accept edge E0: `ready_o` goes 0 after E0.
- CONV iterations occur on edges E1..E27.
- Edge E28 (ENC): `data_o` and `ovf_o` update and `done_o`=1 for one cycle.
  - FSM is IDLE after E28, so `ready_o`=1 in the same cycle as `done_o`.
- Latency from accept edge to new `data_o` is 28 clocks.
- A new request is accepted no earlier than E29; peak throughput is one conversion per 29 clocks.
- `done_o` never asserts without a preceding accept; it is never high for two consecutive cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset then idle: after `rstn_i` is released, all `data_o` = FF, `ready_o`=1, `done_o`=0, `ovf_o`=0.
- `bin_i`=12_345_678, `dp_i`=0, blank=0 -> at E28, `data_o`[7..0] = F9 A4 B0 99 92 82 F8 80, `done_o` pulses once, `ovf_o`=0.
- `bin_i`=1050, `dp_i`=8'h04, blank=1 -> `data_o`[7..4]=FF, [3]=F9, [2]=40, [1]=92, [0]=C0.
- `bin_i`=0 with blank=1 -> [7..1]=FF, [0]=C0. `bin_i`=99_999_999 with blank=0 -> all 90.
- Overflow: `bin_i`=100_000_000 -> all bytes BF, `ovf_o`=1. Then `bin_i`=7 with blank=1 -> `ovf_o`=0, [0]=F8, others FF.
- Handshake and reset:
  - `valid_i` held high with new values during CONV -> ignored, `data_o` unchanged until E28. Back-to-back requests are accepted at E0 and E29.
  - `rstn_i` asserted at E10 -> FF outputs immediately and no `done_o`.

Source files
------------

// File: rtl/bin2sseg_fmt.sv
// rtl/bin2sseg_fmt.sv - 27-bit binary to 8-digit active-low seven-segment formatter
module bin2sseg_fmt (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [26:0]      bin_i,
   input  logic [7:0]       dp_i,
   input  logic             blank_lz_i,
   output logic [7:0][7:0]  data_o,
   output logic             done_o,
   output logic             ovf_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CONV = 2'd1;
   localparam logic [1:0] ST_ENC  = 2'd2;

   localparam logic [26:0] MAX_VAL  = 27'd99_999_999;
   localparam logic [4:0]  LAST_IT  = 5'd26;
   localparam logic [7:0]  SEG_OFF  = 8'hFF;
   localparam logic [7:0]  SEG_DASH = 8'hBF;

   logic [1:0]      state;
   logic [26:0]     bin_sr;
   logic [31:0]     bcd;
   logic [4:0]      cnt;
   logic [7:0]      dp_q;
   logic            blank_q;
   logic            ovf_q;
   logic [31:0]     bcd_adj;
   logic [7:0][7:0] seg_next;

   // Active-low segment pattern for one BCD digit; non-decimal nibbles stay dark.
   function automatic logic [7:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    seg_code = 8'hC0;
         4'd1:    seg_code = 8'hF9;
         4'd2:    seg_code = 8'hA4;
         4'd3:    seg_code = 8'hB0;
         4'd4:    seg_code = 8'h99;
         4'd5:    seg_code = 8'h92;
         4'd6:    seg_code = 8'h82;
         4'd7:    seg_code = 8'hF8;
         4'd8:    seg_code = 8'h80;
         4'd9:    seg_code = 8'h90;
         default: seg_code = SEG_OFF;
      endcase
   endfunction

   // Shift-add-3 correction: every nibble of 5 or more gets +3 before the shift.
   always_comb begin
      logic [3:0] nib;
      nib     = '0;
      bcd_adj = '0;
      for (int i = 0; i < 8; i++) begin
         nib = bcd[4*i +: 4];
         bcd_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
      end
   end

   // Segment bytes from the finished BCD word: scan from the top digit so
   // leading zeros are known, then apply overflow dashes and decimal points.
   always_comb begin
      logic       seen;
      logic [3:0] dig;
      logic [7:0] b;
      seen     = 1'b0;
      dig      = '0;
      b        = SEG_OFF;
      seg_next = '1;
      for (int k = 7; k >= 0; k--) begin
         dig = bcd[4*k +: 4];
         if (dig != 4'd0) seen = 1'b1;
         b = seg_code(dig);
         if (blank_q && !seen && (k != 0)) b = SEG_OFF;
         if (ovf_q) b = SEG_DASH;
         if (dp_q[k]) b[7] = 1'b0;
         seg_next[k] = b;
      end
   end

   // Control FSM plus datapath registers; outputs are all flops.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state   <= ST_IDLE;
         bin_sr  <= '0;
         bcd     <= '0;
         cnt     <= '0;
         dp_q    <= '0;
         blank_q <= 1'b0;
         ovf_q   <= 1'b0;
         ready_o <= 1'b1;
         done_o  <= 1'b0;
         ovf_o   <= 1'b0;
         data_o  <= '1;
      end else begin
         done_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (valid_i) begin
                  bin_sr  <= bin_i;
                  bcd     <= '0;
                  cnt     <= '0;
                  dp_q    <= dp_i;
                  blank_q <= blank_lz_i;
                  ovf_q   <= (bin_i > MAX_VAL);
                  ready_o <= 1'b0;
                  state   <= ST_CONV;
               end
            end
            ST_CONV: begin
               bcd    <= {bcd_adj[30:0], bin_sr[26]};
               bin_sr <= {bin_sr[25:0], 1'b0};
               cnt    <= cnt + 5'd1;
               if (cnt == LAST_IT) state <= ST_ENC;
            end
            ST_ENC: begin
               data_o  <= seg_next;
               ovf_o   <= ovf_q;
               done_o  <= 1'b1;
               ready_o <= 1'b1;
               state   <= ST_IDLE;
            end
            default: begin
               ready_o <= 1'b1;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
